// File: rtl/sc_branch_cond_pkg.sv
// Shared definitions for the branch-condition resolver and its Ticc trap reuse:
// Bicc condition codes, PSR flag bit positions and FSM state encodings.
package sc_branch_cond_pkg;

  localparam logic [3:0] BN   = 4'b0000;
  localparam logic [3:0] BE   = 4'b0001;
  localparam logic [3:0] BLE  = 4'b0010;
  localparam logic [3:0] BL   = 4'b0011;
  localparam logic [3:0] BLEU = 4'b0100;
  localparam logic [3:0] BCS  = 4'b0101;
  localparam logic [3:0] BNEG = 4'b0110;
  localparam logic [3:0] BVS  = 4'b0111;
  localparam logic [3:0] BA   = 4'b1000;
  localparam logic [3:0] BNE  = 4'b1001;
  localparam logic [3:0] BG   = 4'b1010;
  localparam logic [3:0] BGE  = 4'b1011;
  localparam logic [3:0] BGU  = 4'b1100;
  localparam logic [3:0] BCC  = 4'b1101;
  localparam logic [3:0] BPOS = 4'b1110;
  localparam logic [3:0] BVC  = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_CC = 1'b1
  } state_e;

endpackage

// File: rtl/sc_cond_eval.sv
// Combinational Bicc/Ticc condition evaluator: cond field + {N,Z,V,C} -> taken.
module sc_cond_eval
  import sc_branch_cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic n, z, v, c;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign c = flags_i[FLAG_C];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves taken_o unassigned (no latch).
    taken_o = 1'b0;
    case (cond_i)
      BN:   taken_o = 1'b0;
      BE:   taken_o = z;
      BLE:  taken_o = z | (n ^ v);
      BL:   taken_o = n ^ v;
      BLEU: taken_o = c | z;
      BCS:  taken_o = c;
      BNEG: taken_o = n;
      BVS:  taken_o = v;
      BA:   taken_o = 1'b1;
      BNE:  taken_o = ~z;
      BG:   taken_o = ~(z | (n ^ v));
      BGE:  taken_o = ~(n ^ v);
      BGU:  taken_o = ~(c | z);
      BCC:  taken_o = ~c;
      BPOS: taken_o = ~n;
      BVC:  taken_o = ~v;
    endcase
  end

endmodule

// File: rtl/sc_branch_cond.sv
// Branch-condition resolver: accepts a Bicc request, waits one cycle when a flag
// write is in flight, and returns a registered taken/target/annul result to fetch.
module sc_branch_cond
  import sc_branch_cond_pkg::*;
#(
  parameter int DISP_W = 22,
  parameter int ADDR_W = 32
) (
  input  logic              SC_BranchCond_CLOCK_50,
  input  logic              SC_BranchCond_RESET_InLow,
  input  logic              SC_BranchCond_Req_InHigh,
  output logic              SC_BranchCond_Ready_OutHigh,
  input  logic [3:0]        SC_BranchCond_Cond,
  input  logic              SC_BranchCond_Annul,
  input  logic [ADDR_W-1:0] SC_BranchCond_Pc,
  input  logic [DISP_W-1:0] SC_BranchCond_Disp,
  input  logic [3:0]        SC_BranchCond_Flags,
  input  logic              SC_BranchCond_CcPending_InLow,
  input  logic              SC_BranchCond_Flush_InHigh,
  output logic              SC_BranchCond_Valid_OutHigh,
  output logic              SC_BranchCond_Taken_OutHigh,
  output logic [ADDR_W-1:0] SC_BranchCond_Target,
  output logic              SC_BranchCond_AnnulSlot_OutHigh
);

  logic clk, rst_n;
  assign clk   = SC_BranchCond_CLOCK_50;
  assign rst_n = SC_BranchCond_RESET_InLow;

  state_e state_q, state_d;

  logic [3:0]        hold_cond_q;
  logic              hold_annul_q;
  logic [ADDR_W-1:0] hold_pc_q;
  logic [DISP_W-1:0] hold_disp_q;

  logic              valid_q, taken_q, annul_slot_q;
  logic [ADDR_W-1:0] target_q;

  logic ready, accept, load, capture;

  logic [3:0]        cond_sel;
  logic              annul_sel;
  logic [ADDR_W-1:0] pc_sel;
  logic [DISP_W-1:0] disp_sel;
  logic [ADDR_W-1:0] disp_off;
  logic [ADDR_W-1:0] target_d;
  logic              taken_d, annul_slot_d;

  assign ready  = (state_q == ST_IDLE);
  assign accept = SC_BranchCond_Req_InHigh & ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic; a pending flag write diverts the accept into WAIT_CC
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && !SC_BranchCond_Flush_InHigh && !SC_BranchCond_CcPending_InLow)
                    state_d = ST_WAIT_CC;
      ST_WAIT_CC: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: when to snapshot the request and when to load a result
  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load    = accept & ~SC_BranchCond_Flush_InHigh &  SC_BranchCond_CcPending_InLow;
        capture = accept & ~SC_BranchCond_Flush_InHigh & ~SC_BranchCond_CcPending_InLow;
      end
      ST_WAIT_CC: load = ~SC_BranchCond_Flush_InHigh;
      default: ;
    endcase
  end

  // In WAIT_CC the held request is evaluated against the now-updated live flags
  assign cond_sel  = (state_q == ST_WAIT_CC) ? hold_cond_q  : SC_BranchCond_Cond;
  assign annul_sel = (state_q == ST_WAIT_CC) ? hold_annul_q : SC_BranchCond_Annul;
  assign pc_sel    = (state_q == ST_WAIT_CC) ? hold_pc_q    : SC_BranchCond_Pc;
  assign disp_sel  = (state_q == ST_WAIT_CC) ? hold_disp_q  : SC_BranchCond_Disp;

  sc_cond_eval u_cond_eval (
    .cond_i  (cond_sel),
    .flags_i (SC_BranchCond_Flags),
    .taken_o (taken_d)
  );

  assign disp_off = {{(ADDR_W-DISP_W-2){disp_sel[DISP_W-1]}}, disp_sel, 2'b00};
  assign target_d = pc_sel + disp_off;

  // Only conditional taken branches keep the delay slot when the a-bit is set
  assign annul_slot_d = annul_sel & ((cond_sel == BA) | (cond_sel == BN) | ~taken_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cond_q  <= '0;
      hold_annul_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_disp_q  <= '0;
    end else if (capture) begin
      hold_cond_q  <= SC_BranchCond_Cond;
      hold_annul_q <= SC_BranchCond_Annul;
      hold_pc_q    <= SC_BranchCond_Pc;
      hold_disp_q  <= SC_BranchCond_Disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      annul_slot_q <= 1'b0;
      target_q     <= '0;
    end else begin
      valid_q <= load;
      if (load) begin
        taken_q      <= taken_d;
        annul_slot_q <= annul_slot_d;
        target_q     <= target_d;
      end
    end
  end

  // A flush in the result cycle still cancels the pulse for that request
  assign SC_BranchCond_Valid_OutHigh     = valid_q & ~SC_BranchCond_Flush_InHigh;
  assign SC_BranchCond_Ready_OutHigh     = ready;
  assign SC_BranchCond_Taken_OutHigh     = taken_q;
  assign SC_BranchCond_Target            = target_q;
  assign SC_BranchCond_AnnulSlot_OutHigh = annul_slot_q;

endmodule

// File: tb/tb_sc_branch_cond.sv
// Scoreboard bench for sc_branch_cond: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever Valid is high.
module tb_sc_branch_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ready;
  logic [3:0]  cond = 4'h0;
  logic        annul = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [21:0] disp = 22'h0;
  logic [3:0]  flags = 4'h0;
  logic        pend_n = 1'b1;
  logic        flush = 1'b0;
  logic        valid, taken, annul_slot;
  logic [31:0] target;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        annul;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  sc_branch_cond #(.DISP_W(22), .ADDR_W(32)) dut (
    .SC_BranchCond_CLOCK_50          (clk),
    .SC_BranchCond_RESET_InLow       (rst_n),
    .SC_BranchCond_Req_InHigh        (req),
    .SC_BranchCond_Ready_OutHigh     (ready),
    .SC_BranchCond_Cond              (cond),
    .SC_BranchCond_Annul             (annul),
    .SC_BranchCond_Pc                (pc),
    .SC_BranchCond_Disp              (disp),
    .SC_BranchCond_Flags             (flags),
    .SC_BranchCond_CcPending_InLow   (pend_n),
    .SC_BranchCond_Flush_InHigh      (flush),
    .SC_BranchCond_Valid_OutHigh     (valid),
    .SC_BranchCond_Taken_OutHigh     (taken),
    .SC_BranchCond_Target            (target),
    .SC_BranchCond_AnnulSlot_OutHigh (annul_slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: low three bits pick a base test, bit 3 inverts it
  function automatic logic m_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = cy | z;
      3'd5: base = cy;
      3'd6: base = n;
      default: base = v;
    endcase
    return c[3] ? ~base : base;
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] p, input logic [21:0] d);
    logic signed [31:0] sd;
    sd = {{10{d[21]}}, d};
    return p + sd * 32'sd4;
  endfunction

  task automatic drive(input logic [3:0] c, input logic a, input logic [31:0] p,
                       input logic [21:0] d, input logic [3:0] f, input logic pn);
    cond = c; annul = a; pc = p; disp = d; flags = f; pend_n = pn; req = 1'b1;
  endtask

  // One-cycle-path accept with hand-computed expectation; Req stays high
  task automatic acc1(input logic [3:0] c, input logic a, input logic [31:0] p,
                      input logic [21:0] d, input logic [3:0] f,
                      input logic et, input logic [31:0] etg, input logic ea);
    drive(c, a, p, d, f, 1'b1);
    @(posedge clk); #1;
    sb.push_back('{et, etg, ea, cyc});
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("taken", 32'(taken), 32'(e.taken));
        check("target", target, e.target);
        check("annul_slot", 32'(annul_slot), 32'(e.annul));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_annul", 32'(annul_slot), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready), 32'd1);

    // Exhaustive cond x flags, back-to-back on the no-pending path
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic [3:0]  c4, f4;
        logic [31:0] p;
        logic [21:0] d;
        logic        a, t;
        c4 = 4'(c); f4 = 4'(f);
        p  = 32'h4000_0000 + 32'(c * 256);
        d  = {f4, 14'h0, f4};
        a  = f4[0] ^ c4[0];
        t  = m_taken(c4, f4);
        acc1(c4, a, p, d, f4, t, m_target(p, d),
             a & ((c4 == 4'b1000) | (c4 == 4'b0000) | ~t));
      end
    end
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Target arithmetic and annul cases, three of them back-to-back
    acc1(4'b1000, 1'b0, 32'h0000_1000, 22'h3F_FFFF, 4'h0, 1'b1, 32'h0000_0FFC, 1'b0);
    acc1(4'b0000, 1'b1, 32'hFFFF_FFFC, 22'h00_0001, 4'hF, 1'b0, 32'h0000_0000, 1'b1);
    acc1(4'b1000, 1'b1, 32'h0000_2000, 22'h00_0010, 4'h0, 1'b1, 32'h0000_2040, 1'b1);
    req = 1'b0;
    @(posedge clk); #1;
    acc1(4'b1001, 1'b1, 32'h0000_3000, 22'h00_0002, 4'b0100, 1'b0, 32'h0000_3008, 1'b1);
    acc1(4'b1001, 1'b1, 32'h0000_3000, 22'h00_0002, 4'b0000, 1'b1, 32'h0000_3008, 1'b0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Pending stall: flags become 0100 at the accept edge
    drive(4'b0001, 1'b0, 32'h0000_0100, 22'h00_0004, 4'b0000, 1'b0);
    @(posedge clk); #1;
    check("pend_ready_low", 32'(ready), 32'd0);
    sb.push_back('{1'b1, 32'h0000_0110, 1'b0, cyc + 1});
    req = 1'b0; flags = 4'b0100; pend_n = 1'b1;
    @(posedge clk); #1;
    check("pend_ready_back", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Flush while in WAIT_CC
    drive(4'b1000, 1'b1, 32'h0000_0200, 22'h00_0001, 4'h0, 1'b0);
    @(posedge clk); #1;
    req = 1'b0; pend_n = 1'b1; flush = 1'b1;
    check("flush_wait_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_wait_idle", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Flush together with accept in IDLE
    drive(4'b1000, 1'b0, 32'h0000_0300, 22'h00_0001, 4'h0, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    check("flush_acc_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Flush in the result cycle of a 1-cycle accept
    drive(4'b1000, 1'b0, 32'h0000_0400, 22'h00_0001, 4'h0, 1'b1);
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-WAIT_CC after a non-zero result is on the outputs
    acc1(4'b1000, 1'b1, 32'h0000_1234, 22'h00_0001, 4'h0, 1'b1, 32'h0000_1238, 1'b1);
    req = 1'b0;
    @(posedge clk); #1;
    drive(4'b1000, 1'b0, 32'h0000_0500, 22'h00_0001, 4'h0, 1'b0);
    @(posedge clk); #1;
    req = 1'b0; pend_n = 1'b1;
    check("rstmid_ready_low", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #2;
    check("rstmid_taken", 32'(taken), 32'd0);
    check("rstmid_target", target, 32'd0);
    check("rstmid_annul", 32'(annul_slot), 32'd0);
    check("rstmid_valid", 32'(valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_ready", 32'(ready), 32'd1);
    check("rstmid_valid_after", 32'(valid), 32'd0);
    check("rstmid_target_after", target, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_branch_cond.md
# sc_branch_cond

Branch-condition resolver for the SPARC-subset datapath: the consumer of the processor status register's N/Z/V/C flag vector. It accepts a Bicc branch request from decode, evaluates the 4-bit condition field against the current flags, and returns a registered taken/not-taken decision, the 32-bit branch target and the delay-slot annul decision to fetch. When a flag write is pending in the same cycle, it stalls one cycle so that it always evaluates post-write flags.

## Interface
- DISP_W, 22: width of the word displacement field (disp22).
- ADDR_W, 32: PC / target width.
- SC_BranchCond_CLOCK_50  in  1  system clock; all state updates on the rising edge.
- SC_BranchCond_RESET_InLow  in  1  reset, asynchronous, active-low; clears all state and outputs.
- SC_BranchCond_Req_InHigh  in  1  branch request valid.
- SC_BranchCond_Ready_OutHigh  out  1  request can be accepted this cycle.
- SC_BranchCond_Cond  in  4  Bicc cond field.
- SC_BranchCond_Annul  in  1  instruction a-bit.
- SC_BranchCond_Pc  in  ADDR_W  address of the branch instruction.
- SC_BranchCond_Disp  in  DISP_W  signed word displacement.
- SC_BranchCond_Flags  in  4  {N,Z,V,C}, bit 3 = N, same ordering as the PSR output.
- SC_BranchCond_CcPending_InLow  in  1  low = flag register loads new flags at this edge.
- SC_BranchCond_Flush_InHigh  in  1  synchronous abandon of any held request.
- SC_BranchCond_Valid_OutHigh  out  1  result valid, one-cycle pulse.
- SC_BranchCond_Taken_OutHigh  out  1  branch taken.
- SC_BranchCond_Target  out  ADDR_W  branch target.
- SC_BranchCond_AnnulSlot_OutHigh  out  1  squash the delay-slot instruction.

## Operation
- FSM states: IDLE and WAIT_CC. Ready is 1 only in IDLE.
- Accept = Req & Ready at a rising edge.
- Accept with CcPending_InLow = 1:
  - Evaluate with the Flags sampled at that edge.
  - Load the result registers and pulse Valid in the next cycle.
  - Stay in IDLE.
- Accept with CcPending_InLow = 0:
  - Latch Cond/Annul/Pc/Disp into holding registers and go to WAIT_CC.
  - At the next edge, evaluate with the Flags present then, load the result registers and return to IDLE.
  - CcPending is not re-checked in WAIT_CC.
- Conditions (1 = taken):
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V.
  - 0100 C|Z; 0101 C; 0110 N; 0111 V.
  - 1000 always; 1001–1111 are the complements of 0001–0111 in the same order.
- Target = Pc + (sign_extend(Disp) << 2), computed modulo 2^ADDR_W; wrap-around is silent.
- Target is driven for not-taken results too.
- AnnulSlot:
  - Annul & (cond==1000 | cond==0000 | !taken).
  - Conditional taken branches always execute the delay slot.
- Flush:
  - In WAIT_CC: drop the request, no Valid, return to IDLE.
  - Flush together with Accept in IDLE: the request is discarded.
  - Flush in the cycle after a 1-cycle accept suppresses that Valid.
- Reset values: state IDLE, Valid 0, Taken 0, AnnulSlot 0, Target 0, holding registers 0. Ready is 1 once reset is released.

## Timing
- Latency from accept edge to Valid high: 1 cycle with no flag write pending, 2 cycles in the WAIT_CC path.
- Valid is high for exactly one cycle per accepted, unflushed request.
- Taken/Target/AnnulSlot hold their values until the next result load.
- Back-to-back accepts on consecutive edges are legal on the no-pending path.
- Reset assertion mid-WAIT_CC: immediate clear, no Valid ever issued for that request.
- Req while Ready = 0 is ignored; decode must hold Req.

## Structure
- Shared header/package holds:
  - condition-code localparams (BN..BVC);
  - flag bit indices N=3, Z=2, V=1, C=0;
  - FSM state encodings.
- One natural sub-module, sc_cond_eval: purely combinational (4-bit cond, 4-bit flags) -> taken. It is reused later by Ticc trap logic.
- Top level holds the FSM, the holding registers, the target adder and the output registers.

## Test plan
- Exhaustive: all 16 cond × 16 flag values, CcPending_InLow = 1 -> Valid one cycle after accept; Taken matches the table (e.g. cond 0010, flags 1000 -> taken).
- Pending stall: accept cond 0001 with flags 0000 and CcPending_InLow = 0; flags become 0100 at that edge -> Ready 0 for one cycle, Valid 2 cycles after accept, Taken = 1.
- Target arithmetic:
  - Pc 0x00001000, Disp 0x3FFFFF -> 0x00000FFC.
  - Pc 0xFFFFFFFC, Disp 1 -> 0x00000000.
- Annul cases: BA a=1 -> Taken 1, AnnulSlot 1; BNE a=1 with Z=1 -> Taken 0, AnnulSlot 1; BNE a=1 with Z=0 -> Taken 1, AnnulSlot 0.
- Flush in WAIT_CC and reset asserted mid-WAIT_CC -> no Valid, IDLE, Ready 1 after release, outputs 0 after reset.
- Back-to-back: three accepts on consecutive edges -> three consecutive Valid pulses with matching results.
